// File: rtl/z80kaa_pkg.sv
// Shared Z80Kaa definitions: I/O bridge FSM encoding,
// port index constants and the write-strobe helper.
package z80kaa_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    CAPTURE = ST_CAPTURE,
    WAIT    = ST_WAIT,
    HOLD    = ST_HOLD
  } io_state_t;

  localparam logic [1:0] PORT_A   = 2'd0;
  localparam logic [1:0] PORT_B   = 2'd1;
  localparam logic [1:0] PORT_IN  = 2'd2;
  localparam logic [1:0] PORT_SCR = 2'd3;

  function automatic logic [3:0] onehot4(
    input logic [1:0] idx
  );
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/z80_sync2.sv
// Two-flop synchroniser for one active-low Z80 strobe.
// Ports: clk, rst (async, active low), d (async in), q (synced, resets to 1).
module z80_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff1 <= 1'b1;
      q   <= 1'b1;
    end else begin
      ff1 <= d;
      q   <= ff1;
    end
  end

endmodule

// File: rtl/z80_io_port.sv
// Z80 I/O-cycle bridge: decodes four ports at adr[3:2]==BASE,
// stretches the cycle with wait_n and drives read data.
// Ports: in_clock, rst (async low); Z80 bus adr, data_in,
// iorq, rd, wr, m1 in; data_out, data_oe, wait_n out;
// port_a, port_b, wr_pulse out; port_in in.
import z80kaa_pkg::*;

module z80_io_port #(
  parameter logic [1:0] BASE        = 2'b00,
  parameter int         WAIT_CYCLES = 4
) (
  input  logic       in_clock,
  input  logic       rst,
  input  logic [3:0] adr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic       iorq,
  input  logic       rd,
  input  logic       wr,
  input  logic       m1,
  output logic       wait_n,
  output logic [7:0] port_a,
  output logic [7:0] port_b,
  input  logic [7:0] port_in,
  output logic [3:0] wr_pulse
);

  localparam logic       HAS_WAIT = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES - 1);

  logic s_iorq;
  logic s_rd;
  logic s_wr;
  logic s_m1;

  z80_sync2 u_sync_iorq (
    .clk (in_clock),
    .rst (rst),
    .d   (iorq),
    .q   (s_iorq)
  );

  z80_sync2 u_sync_rd (
    .clk (in_clock),
    .rst (rst),
    .d   (rd),
    .q   (s_rd)
  );

  z80_sync2 u_sync_wr (
    .clk (in_clock),
    .rst (rst),
    .d   (wr),
    .q   (s_wr)
  );

  z80_sync2 u_sync_m1 (
    .clk (in_clock),
    .rst (rst),
    .d   (m1),
    .q   (s_m1)
  );

  io_state_t  state;
  logic [3:0] cnt;
  logic [7:0] scratch;
  logic       hit;
  logic       start;
  logic [7:0] rd_mux;

  // m1 low with iorq low is an interrupt acknowledge
  assign hit   = !s_iorq && s_m1 && (adr[3:2] == BASE);
  assign start = hit && (!s_wr || !s_rd);

  always_comb begin
    rd_mux = 8'h00;
    case (adr[1:0])
      PORT_A:   rd_mux = port_a;
      PORT_B:   rd_mux = port_b;
      PORT_IN:  rd_mux = port_in;
      PORT_SCR: rd_mux = scratch;
      default:  rd_mux = 8'h00;
    endcase
  end

  // Outputs are registered on the edge that enters
  // each state, so they describe the state held.
  always_ff @(posedge in_clock or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      port_a   <= 8'h00;
      port_b   <= 8'h00;
      scratch  <= 8'h00;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      wait_n   <= 1'b1;
      wr_pulse <= 4'b0000;
    end else begin
      wr_pulse <= 4'b0000;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CAPTURE;
            // wr wins when rd and wr are both low
            if (!s_wr) begin
              wr_pulse <= onehot4(adr[1:0]);
              case (adr[1:0])
                PORT_A:   port_a  <= data_in;
                PORT_B:   port_b  <= data_in;
                PORT_SCR: scratch <= data_in;
                default:  ;
              endcase
            end else begin
              data_oe  <= 1'b1;
              data_out <= rd_mux;
            end
          end
        end
        CAPTURE: begin
          if (HAS_WAIT) begin
            state  <= WAIT;
            wait_n <= 1'b0;
            cnt    <= WAIT_LD;
          end else begin
            state <= HOLD;
          end
        end
        WAIT: begin
          if (s_iorq) begin
            state   <= IDLE;
            wait_n  <= 1'b1;
            data_oe <= 1'b0;
          end else if (cnt == 4'd0) begin
            state  <= HOLD;
            wait_n <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (s_iorq) begin
            state   <= IDLE;
            data_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_io_port.sv
// Bench for z80_io_port: scripted bus cycles plus random
// traffic against a transaction-level reference model.
module tb_z80_io_port;

  localparam int W = 4;

  logic       in_clock = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] adr = 4'h0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe;
  logic       iorq = 1'b1;
  logic       rd = 1'b1;
  logic       wr = 1'b1;
  logic       m1 = 1'b1;
  logic       wait_n;
  logic [7:0] port_a;
  logic [7:0] port_b;
  logic [7:0] port_in = 8'h00;
  logic [3:0] wr_pulse;

  z80_io_port #(
    .BASE        (2'b00),
    .WAIT_CYCLES (W)
  ) dut (
    .in_clock (in_clock),
    .rst      (rst),
    .adr      (adr),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .iorq     (iorq),
    .rd       (rd),
    .wr       (wr),
    .m1       (m1),
    .wait_n   (wait_n),
    .port_a   (port_a),
    .port_b   (port_b),
    .port_in  (port_in),
    .wr_pulse (wr_pulse)
  );

  always #5 in_clock = ~in_clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: strobes seen two clocks late; an
  // access is tracked by its age in clocks since it was
  // accepted (0 = capture, 1..W = wait, later = hold).
  logic [3:0] q1, q2;
  int         age;
  bit         m_wr;
  logic [7:0] m_a, m_b, m_scr, m_dout;
  logic [3:0] m_pulse;

  task automatic model_reset();
    q1 = 4'hF;
    q2 = 4'hF;
    age = -1;
    m_wr = 1'b0;
    m_a = 8'h00;
    m_b = 8'h00;
    m_scr = 8'h00;
    m_dout = 8'h00;
    m_pulse = 4'h0;
  endtask

  task automatic model_step();
    logic si, sr, sw, sm;
    {si, sr, sw, sm} = q2;
    if (age >= 0) begin
      if (age >= 1 && si) age = -1;
      else age++;
    end else if (!si && sm && adr[3:2] == 2'b00
                 && (!sw || !sr)) begin
      age = 0;
      m_wr = !sw;
      if (m_wr) begin
        m_pulse = 4'b0001 << adr[1:0];
        if (adr[1:0] == 2'd0) m_a = data_in;
        if (adr[1:0] == 2'd1) m_b = data_in;
        if (adr[1:0] == 2'd3) m_scr = data_in;
      end else begin
        if (adr[1:0] == 2'd0) m_dout = m_a;
        if (adr[1:0] == 2'd1) m_dout = m_b;
        if (adr[1:0] == 2'd2) m_dout = port_in;
        if (adr[1:0] == 2'd3) m_dout = m_scr;
      end
    end
    q2 = q1;
    q1 = {iorq, rd, wr, m1};
  endtask

  initial begin
    forever begin
      logic exp_oe;
      @(negedge in_clock);
      if (!rst) model_reset();
      exp_oe = (age >= 0) && !m_wr;
      chk("port_a", port_a, m_a);
      chk("port_b", port_b, m_b);
      chk("wr_pulse", wr_pulse,
          (age == 0 && m_wr) ? m_pulse : 4'h0);
      chk("wait_n", wait_n, !(age >= 1 && age <= W));
      chk("data_oe", data_oe, exp_oe);
      if (exp_oe) chk("data_out", data_out, m_dout);
      if (rst) model_step();
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // kind: 0 read, 1 write, 2 rd+wr, 3 neither
  task automatic io(input logic [3:0] a,
                    input logic [7:0] d,
                    input int kind,
                    input logic m1v,
                    input int hold,
                    input int tail,
                    output int pulses,
                    output logic [3:0] pv,
                    output int wlow,
                    output int oe_n,
                    output logic [7:0] dseen,
                    output int t_first);
    int k;
    pulses = 0; pv = 4'h0; wlow = 0;
    oe_n = 0; dseen = 8'h00; t_first = 0; k = 0;
    @(posedge in_clock); #1;
    adr = a; data_in = d; m1 = m1v; iorq = 1'b0;
    rd = !(kind == 0 || kind == 2);
    wr = !(kind == 1 || kind == 2);
    repeat (hold + tail) begin
      @(negedge in_clock);
      k++;
      if (wr_pulse != 4'h0) begin
        pulses++;
        pv = wr_pulse;
      end
      if (!wait_n) wlow++;
      if (data_oe) begin
        oe_n++;
        dseen = data_out;
      end
      if (t_first == 0 && (wr_pulse != 0 || data_oe))
        t_first = k;
      if (k == hold) begin
        @(posedge in_clock); #1;
        iorq = 1'b1; rd = 1'b1; wr = 1'b1; m1 = 1'b1;
      end
    end
  endtask

  initial begin
    int p, wl, oe, tf;
    logic [3:0] pv;
    logic [7:0] ds;
    bit seen;

    // reset with a bus cycle active
    iorq = 1'b0; wr = 1'b0; data_in = 8'hA5;
    repeat (4) @(negedge in_clock);
    chk("rst_port_a", port_a, 8'h00);
    chk("rst_port_b", port_b, 8'h00);
    chk("rst_wait_n", wait_n, 1'b1);
    chk("rst_data_oe", data_oe, 1'b0);
    chk("rst_wr_pulse", wr_pulse, 4'h0);
    @(posedge in_clock); #1;
    iorq = 1'b1; wr = 1'b1;
    repeat (2) @(posedge in_clock);
    #1 rst = 1'b1;
    repeat (3) @(posedge in_clock);

    io(4'h0, 8'hA5, 1, 1'b1, 12, 4, p, pv, wl, oe, ds, tf);
    chk("wrA_port_a", port_a, 8'hA5);
    chk("wrA_pulse_cnt", p, 1);
    chk("wrA_pulse_val", pv, 4'b0001);
    chk("wrA_latency", tf, 4);
    chk("wrA_wait_len", wl, 4);

    io(4'h3, 8'h3C, 1, 1'b1, 12, 4, p, pv, wl, oe, ds, tf);
    chk("wrS_pulse_val", pv, 4'b1000);
    io(4'h3, 8'h00, 0, 1'b1, 12, 4, p, pv, wl, oe, ds, tf);
    chk("rdS_data", ds, 8'h3C);
    chk("rdS_latency", tf, 4);
    chk("rdS_oe_off", data_oe, 1'b0);
    chk("rdS_no_pulse", p, 0);

    @(posedge in_clock); #1 port_in = 8'h5A;
    io(4'h2, 8'h00, 0, 1'b1, 12, 4, p, pv, wl, oe, ds, tf);
    chk("rdIn_data", ds, 8'h5A);
    io(4'h4, 8'h99, 1, 1'b1, 12, 4, p, pv, wl, oe, ds, tf);
    chk("miss_pulse", p, 0);
    chk("miss_wait", wl, 0);

    io(4'h0, 8'h11, 3, 1'b0, 12, 4, p, pv, wl, oe, ds, tf);
    chk("intack_oe", oe, 0);
    chk("intack_wait", wl, 0);
    io(4'h0, 8'h11, 1, 1'b0, 12, 4, p, pv, wl, oe, ds, tf);
    chk("intack_wr_port_a", port_a, 8'hA5);
    chk("intack_wr_pulse", p, 0);

    // release iorq early so it is seen mid-wait
    io(4'h1, 8'h42, 1, 1'b1, 4, 6, p, pv, wl, oe, ds, tf);
    chk("abort_wait_len", wl, 3);
    chk("abort_port_b", port_b, 8'h42);
    chk("abort_wait_n", wait_n, 1'b1);

    // async reset in the middle of a wait
    @(posedge in_clock); #1;
    adr = 4'h1; data_in = 8'h77; iorq = 1'b0; wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge in_clock);
      if (!wait_n) seen = 1'b1;
    end
    chk("midwait_reached", seen, 1'b1);
    @(posedge in_clock); #1 rst = 1'b0;
    #1;
    chk("midrst_wait_n", wait_n, 1'b1);
    chk("midrst_port_b", port_b, 8'h00);
    chk("midrst_port_a", port_a, 8'h00);
    chk("midrst_oe", data_oe, 1'b0);
    iorq = 1'b1; wr = 1'b1;
    @(posedge in_clock); #1 rst = 1'b1;

    for (int t = 0; t < 250; t++) begin
      @(posedge in_clock); #1 port_in = 8'($urandom);
      io(4'($urandom_range(0, 15)), 8'($urandom),
         int'($urandom_range(0, 3)),
         ($urandom_range(0, 7) != 0),
         int'($urandom_range(1, 14)),
         int'($urandom_range(1, 5)),
         p, pv, wl, oe, ds, tf);
    end

    repeat (4) @(negedge in_clock);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
